// File: rtl/sig_ctrl_pkg.sv
// Shared definitions for the timed highway/farm-road signal controller.
//   - Lamp codes driven onto hwy/fwy (GREEN/YELLOW/RED/OFF).
//   - FSM state encoding (HG..FLASH), exposed on the controller's state port.
//   - lights(): Moore decode of a state (plus blink in FLASH) to {hwy, fwy}.
package sig_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] OFF    = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    HG    = 3'd0,  // highway green
    HY    = 3'd1,  // highway yellow
    ARF   = 3'd2,  // all-red clearance before farm-road green
    FG    = 3'd3,  // farm-road green
    FY    = 3'd4,  // farm-road yellow
    ARH   = 3'd5,  // all-red clearance before highway green
    FLASH = 3'd6   // maintenance flash
  } state_e;

  // Returns {hwy, fwy}.
  function automatic logic [3:0] lights(input state_e s, input logic blink);
    logic [3:0] l;
    case (s)
      HG:      l = {GREEN, RED};
      HY:      l = {YELLOW, RED};
      ARF:     l = {RED, RED};
      FG:      l = {RED, GREEN};
      FY:      l = {RED, YELLOW};
      ARH:     l = {RED, RED};
      FLASH:   l = blink ? {YELLOW, YELLOW} : {OFF, OFF};
      default: l = {RED, RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sig_controller_timed_tick_gen.sv
// Timing-tick prescaler.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clr_i  : synchronous clear; restarts the count so the next tick comes
//            exactly CLK_DIV cycles later
//   tick_o : high for one cycle when the count reaches CLK_DIV-1
module tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sig_controller_timed.sv
// Timed highway/farm-road signal controller with min/max green, all-red
// clearance and maintenance flash.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active LOW despite the name
//   X     : farm-road vehicle sensor (asynchronous, synchronised here)
//   flash : maintenance flash request (synchronous)
//   hwy   : highway lamp code
//   fwy   : farm-road lamp code
//   state : current FSM state (debug)
// Phase timing is counted in prescaled ticks; every state change restarts
// the prescaler and the elapsed-tick counter, so a state lasting D ticks
// lasts exactly D*CLK_DIV clock cycles.
module sig_controller_timed
  import sig_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CNT_W    = 8,
  parameter int HG_MIN_T = 3,
  parameter int YEL_T    = 2,
  parameter int AR_T     = 1,
  parameter int FG_MIN_T = 2,
  parameter int FG_MAX_T = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               X,
  input  logic               flash,
  output logic [1:0]         hwy,
  output logic [1:0]         fwy,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] ELAPSED_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   HG_MIN_N    = (CNT_W+1)'(HG_MIN_T);
  localparam logic [CNT_W:0]   YEL_N       = (CNT_W+1)'(YEL_T);
  localparam logic [CNT_W:0]   AR_N        = (CNT_W+1)'(AR_T);
  localparam logic [CNT_W:0]   FG_MIN_N    = (CNT_W+1)'(FG_MIN_T);
  localparam logic [CNT_W:0]   FG_MAX_N    = (CNT_W+1)'(FG_MAX_T);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             blink_q, blink_d;
  logic             x_meta_q, xs_q;
  logic [1:0]       hwy_q, hwy_d, fwy_q, fwy_d;
  logic             tick;
  logic             state_chg;
  logic [CNT_W:0]   n;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (state_chg),
    .tick_o (tick)
  );

  // One bit wider than the counter so a saturated count cannot wrap n.
  assign n = {1'b0, elapsed_q} + (CNT_W+1)'(1);

  always_comb begin
    state_d   = state_q;
    blink_d   = blink_q;
    elapsed_d = elapsed_q;

    // Flash request overrides any timed transition in the same cycle.
    if (flash && (state_q != FLASH)) begin
      state_d = FLASH;
    end else begin
      case (state_q)
        HG:    if (tick && (n >= HG_MIN_N) && xs_q) state_d = HY;
        HY:    if (tick && (n == YEL_N))            state_d = ARF;
        ARF:   if (tick && (n == AR_N))             state_d = FG;
        FG:    if (tick && (((n >= FG_MIN_N) && !xs_q) || (n == FG_MAX_N)))
                 state_d = FY;
        FY:    if (tick && (n == YEL_N))            state_d = ARH;
        ARH:   if (tick && (n == AR_N))             state_d = HG;
        // Leaving flash always goes through clearance before highway green.
        FLASH: if (!flash)   state_d = ARH;
               else if (tick) blink_d = ~blink_q;
        default: state_d = HG;
      endcase
    end

    state_chg = (state_d != state_q);

    if (state_d != FLASH)      blink_d = 1'b0;
    else if (state_q != FLASH) blink_d = 1'b1;

    if (state_chg)                          elapsed_d = '0;
    else if (tick && (elapsed_q != ELAPSED_MAX)) elapsed_d = elapsed_q + CNT_W'(1);

    // Lamp registers load the decode of the next state, so they always
    // match the state register with no extra latency.
    {hwy_d, fwy_d} = lights(state_d, blink_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HG;
      elapsed_q <= '0;
      blink_q   <= 1'b0;
      x_meta_q  <= 1'b0;
      xs_q      <= 1'b0;
      hwy_q     <= GREEN;
      fwy_q     <= RED;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      blink_q   <= blink_d;
      x_meta_q  <= X;
      xs_q      <= x_meta_q;
      hwy_q     <= hwy_d;
      fwy_q     <= fwy_d;
    end
  end

  assign hwy   = hwy_q;
  assign fwy   = fwy_q;
  assign state = state_q;

endmodule

// File: tb/tb_sig_controller_timed.sv
module tb_sig_controller_timed;

  logic       clk;
  logic       rst;
  logic       X;
  logic       flash;
  logic [1:0] hwy;
  logic [1:0] fwy;
  logic [2:0] state;

  // Observed vector: {state, hwy, fwy}
  logic [6:0] obs;
  assign obs = {state, hwy, fwy};

  localparam logic [6:0] V_HG  = 7'b000_00_10;
  localparam logic [6:0] V_HY  = 7'b001_01_10;
  localparam logic [6:0] V_ARF = 7'b010_10_10;
  localparam logic [6:0] V_FG  = 7'b011_10_00;
  localparam logic [6:0] V_FY  = 7'b100_10_01;
  localparam logic [6:0] V_ARH = 7'b101_10_10;
  localparam logic [6:0] V_FL1 = 7'b110_01_01;
  localparam logic [6:0] V_FL0 = 7'b110_11_11;

  int total = 0;
  int bad   = 0;

  sig_controller_timed dut (
    .clk   (clk),
    .rst   (rst),
    .X     (X),
    .flash (flash),
    .hwy   (hwy),
    .fwy   (fwy),
    .state (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // check exp on each of 'cycles' consecutive samples, ending one step later
  task automatic expect_phase(input string tag, input logic [6:0] exp, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk(tag, exp);
      step(1);
    end
  endtask

  // bounded wait for the state field to reach exp; timeout is a failure
  task automatic wait_state(input string tag, input logic [6:0] exp, input int budget);
    int k;
    k = 0;
    while ((state !== exp[6:4]) && (k < budget)) begin
      step(1);
      k++;
    end
    chk(tag, exp);
  endtask

  initial begin
    rst   = 1'b1;
    X     = 1'b0;
    flash = 1'b0;

    // 1. reset idle
    #2 rst = 1'b0;
    #1 chk("reset", V_HG);
    step(3);
    chk("reset_held", V_HG);
    rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      chk("idle_hg", V_HG);
    end

    // 2. full cycle with X held high
    X = 1'b1;
    wait_state("enter_hy", V_HY, 20);
    expect_phase("hy_8", V_HY, 8);
    expect_phase("arf_4", V_ARF, 4);
    expect_phase("fg_max_20", V_FG, 20);
    expect_phase("fy_8", V_FY, 8);
    expect_phase("arh_4", V_ARH, 4);
    expect_phase("hg_min_12", V_HG, 12);
    chk("hy_again", V_HY);

    // 3. early farm-road release
    expect_phase("hy_8b", V_HY, 8);
    expect_phase("arf_4b", V_ARF, 4);
    chk("fg_entry", V_FG);
    step(1);
    X = 1'b0;
    expect_phase("fg_early_8", V_FG, 7);
    expect_phase("fy_8b", V_FY, 8);
    expect_phase("arh_4b", V_ARH, 4);
    chk("hg_back", V_HG);

    // 4. flash mid-FG
    X = 1'b1;
    wait_state("enter_hy_c", V_HY, 30);
    expect_phase("hy_8c", V_HY, 8);
    expect_phase("arf_4c", V_ARF, 4);
    chk("fg_c0", V_FG);
    step(1);
    chk("fg_c1", V_FG);
    flash = 1'b1;
    step(1);
    expect_phase("flash_on_a", V_FL1, 4);
    expect_phase("flash_off", V_FL0, 4);
    expect_phase("flash_on_b", V_FL1, 3);
    chk("flash_on_b_last", V_FL1);
    flash = 1'b0;
    X = 1'b0;
    step(1);
    expect_phase("flash_exit_arh", V_ARH, 4);
    chk("flash_exit_hg", V_HG);

    // 5. asynchronous reset mid-HY
    X = 1'b1;
    wait_state("enter_hy_d", V_HY, 30);
    step(2);
    chk("hy_d_mid", V_HY);
    #3 rst = 1'b0;
    #1 chk("async_reset", V_HG);
    step(2);
    chk("reset_hold_d", V_HG);
    rst = 1'b1;
    step(1);
    expect_phase("hg_fresh_min", V_HG, 11);
    chk("hy_after_reset", V_HY);

    // 6. glitch rejection: X pulse away from a tick, HG past minimum
    X = 1'b0;
    wait_state("back_to_hg", V_HG, 100);
    step(16);
    X = 1'b1;
    step(1);
    X = 1'b0;
    expect_phase("glitch_hg_hold", V_HG, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
